// File: rtl/inst_fetch_responder_if.sv
// -----------------------------------------------------------------------------
// inst_fetch_responder_if
// Bundles the core-side fetch handshake and the memory-side read port of the
// instruction fetch responder.
//   slave  modport : the fetch responder itself
//   master modport : the environment (core + instruction memory)
// Core side  : PC/PC_VALID/PC_READY request, INST/INST_PC/INST_VALID/
//              INST_READY/INST_FAULT response, FLUSH redirect, FETCH_COUNT.
// Memory side: MEM_REQ/MEM_ADDR/MEM_GNT request, MEM_RVALID/MEM_RDATA response.
// -----------------------------------------------------------------------------
interface inst_fetch_responder_if;
  logic [31:0] PC;
  logic        PC_VALID;
  logic        PC_READY;
  logic [31:0] INST;
  logic [31:0] INST_PC;
  logic        INST_VALID;
  logic        INST_READY;
  logic        INST_FAULT;
  logic        FLUSH;
  logic        MEM_REQ;
  logic [31:0] MEM_ADDR;
  logic        MEM_GNT;
  logic        MEM_RVALID;
  logic [31:0] MEM_RDATA;
  logic [31:0] FETCH_COUNT;

  modport slave (
    input  PC, PC_VALID, INST_READY, FLUSH, MEM_GNT, MEM_RVALID, MEM_RDATA,
    output PC_READY, INST, INST_PC, INST_VALID, INST_FAULT, MEM_REQ, MEM_ADDR,
           FETCH_COUNT
  );

  modport master (
    output PC, PC_VALID, INST_READY, FLUSH, MEM_GNT, MEM_RVALID, MEM_RDATA,
    input  PC_READY, INST, INST_PC, INST_VALID, INST_FAULT, MEM_REQ, MEM_ADDR,
           FETCH_COUNT
  );
endinterface

// File: rtl/inst_fetch_responder.sv
// -----------------------------------------------------------------------------
// inst_fetch_responder
// Single-outstanding instruction fetch unit between a core and a word-addressed
// instruction memory. Accepts one fetch address at a time, issues one memory
// read, and holds the returned word until the core consumes it. Misaligned
// addresses are answered locally with a NOP and INST_FAULT set. FLUSH abandons
// the fetch in flight; a read already granted is drained and its data dropped.
// Ports:
//   CLOCK   : clock, all state on rising edge
//   RESET_N : asynchronous active-low reset
//   bus     : inst_fetch_responder_if.slave (core and memory handshakes)
// All interface outputs come straight from registers.
// -----------------------------------------------------------------------------
module inst_fetch_responder #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] NOP_INST     = 32'h0000_0013
) (
  input logic                   CLOCK,
  input logic                   RESET_N,
  inst_fetch_responder_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_DATA  = 3'd2,
    S_HOLD  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next_state;

  logic        r_pc_ready;
  logic        r_mem_req;
  logic        r_inst_valid;
  logic        r_inst_fault;
  logic [31:0] r_mem_addr;
  logic [31:0] r_inst;
  logic [31:0] r_inst_pc;
  logic [31:0] r_fetch_count;

  logic        w_pc_ready;
  logic        w_mem_req;
  logic        w_inst_valid;
  logic        w_inst_fault;
  logic [31:0] w_mem_addr;
  logic [31:0] w_inst;
  logic [31:0] w_inst_pc;
  logic [31:0] w_fetch_count;

  // Next-state and next-output decode; handshake outputs are derived from the
  // next state so that they can be registered without a cycle of lag.
  always_comb begin
    w_next_state  = r_state;
    w_mem_addr    = r_mem_addr;
    w_inst        = r_inst;
    w_inst_pc     = r_inst_pc;
    w_inst_fault  = r_inst_fault;
    w_fetch_count = r_fetch_count;

    case (r_state)
      S_IDLE: begin
        // FLUSH has nothing to abandon here, so it is deliberately not decoded.
        if (bus.PC_VALID) begin
          w_inst_pc  = bus.PC;
          w_mem_addr = {bus.PC[31:2], 2'b00};
          if (bus.PC[1:0] != 2'b00) begin
            w_next_state = S_HOLD;
            w_inst       = NOP_INST;
            w_inst_fault = 1'b1;
          end else begin
            w_next_state = S_ADDR;
          end
        end else begin
          w_next_state = S_IDLE;
        end
      end

      S_ADDR: begin
        // Once granted, a response is owed even if flushed: drain it.
        if (bus.MEM_GNT) begin
          if (bus.FLUSH) begin
            w_next_state = S_DRAIN;
          end else begin
            w_next_state = S_DATA;
          end
        end else if (bus.FLUSH) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_ADDR;
        end
      end

      S_DATA: begin
        if (bus.MEM_RVALID) begin
          if (bus.FLUSH) begin
            w_next_state = S_IDLE;
          end else begin
            w_next_state = S_HOLD;
            w_inst       = bus.MEM_RDATA;
            w_inst_fault = 1'b0;
          end
        end else if (bus.FLUSH) begin
          w_next_state = S_DRAIN;
        end else begin
          w_next_state = S_DATA;
        end
      end

      S_HOLD: begin
        // FLUSH wins over INST_READY: a redirected instruction is not counted.
        if (bus.FLUSH) begin
          w_next_state = S_IDLE;
          w_inst       = NOP_INST;
          w_inst_fault = 1'b0;
        end else if (bus.INST_READY) begin
          w_next_state  = S_IDLE;
          w_inst        = NOP_INST;
          w_inst_fault  = 1'b0;
          w_fetch_count = r_fetch_count + 32'd1;
        end else begin
          w_next_state = S_HOLD;
        end
      end

      S_DRAIN: begin
        if (bus.MEM_RVALID) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_DRAIN;
        end
      end

      default: begin
        w_next_state = S_IDLE;
        w_inst       = NOP_INST;
        w_inst_fault = 1'b0;
      end
    endcase

    w_pc_ready   = (w_next_state == S_IDLE);
    w_mem_req    = (w_next_state == S_ADDR);
    w_inst_valid = (w_next_state == S_HOLD);
  end

  // State and output registers.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state       <= S_IDLE;
      r_pc_ready    <= 1'b1;
      r_mem_req     <= 1'b0;
      r_inst_valid  <= 1'b0;
      r_inst_fault  <= 1'b0;
      r_mem_addr    <= {RESET_VECTOR[31:2], 2'b00};
      r_inst        <= NOP_INST;
      r_inst_pc     <= RESET_VECTOR;
      r_fetch_count <= 32'd0;
    end else begin
      r_state       <= w_next_state;
      r_pc_ready    <= w_pc_ready;
      r_mem_req     <= w_mem_req;
      r_inst_valid  <= w_inst_valid;
      r_inst_fault  <= w_inst_fault;
      r_mem_addr    <= w_mem_addr;
      r_inst        <= w_inst;
      r_inst_pc     <= w_inst_pc;
      r_fetch_count <= w_fetch_count;
    end
  end

  assign bus.PC_READY    = r_pc_ready;
  assign bus.MEM_REQ     = r_mem_req;
  assign bus.MEM_ADDR    = r_mem_addr;
  assign bus.INST_VALID  = r_inst_valid;
  assign bus.INST_FAULT  = r_inst_fault;
  assign bus.INST        = r_inst;
  assign bus.INST_PC     = r_inst_pc;
  assign bus.FETCH_COUNT = r_fetch_count;

endmodule

// File: tb/tb_inst_fetch_responder.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_responder
// Directed stimulus for inst_fetch_responder. A transaction-level model holds
// the instructions the core is expected to consume (queue) and the number of
// consumptions; a compare process checks protocol rules and the model on every
// falling edge. Directed checks pin literal values along the way.
// -----------------------------------------------------------------------------
module tb_inst_fetch_responder;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic CLOCK = 1'b0;
  logic RESET_N;
  int   checks   = 0;
  int   failures = 0;

  inst_fetch_responder_if bus();

  inst_fetch_responder dut (
    .CLOCK   (CLOCK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%b required=%b", name, act, exp);
    end
  endtask

  // ---------------- model ----------------
  logic [31:0] exp_inst_q[$];
  logic [31:0] exp_pc_q[$];
  logic        exp_fault_q[$];
  int          model_count = 0;

  logic        prev_hold = 1'b0;
  logic        prev_req  = 1'b0;
  logic [31:0] prev_inst, prev_pc, prev_addr;
  logic        prev_fault;

  task automatic expect_inst(input logic [31:0] inst, input logic [31:0] pc, input logic fault);
    exp_inst_q.push_back(inst);
    exp_pc_q.push_back(pc);
    exp_fault_q.push_back(fault);
  endtask

  // Per-cycle compare against the model and the protocol rules.
  always @(negedge CLOCK) begin
    if (!RESET_N) begin
      model_count = 0;
      prev_hold   = 1'b0;
      prev_req    = 1'b0;
    end else begin
      chk("fetch_count_model", bus.FETCH_COUNT, model_count);
      chk("mem_addr_word", {30'd0, bus.MEM_ADDR[1:0]}, 32'd0);
      chk1("valid_and_req_exclusive", bus.INST_VALID & bus.MEM_REQ, 1'b0);
      chk1("ready_only_when_idle", bus.PC_READY & (bus.INST_VALID | bus.MEM_REQ), 1'b0);
      if (prev_hold) begin
        chk1("hold_valid_stable", bus.INST_VALID, 1'b1);
        chk("hold_inst_stable", bus.INST, prev_inst);
        chk("hold_pc_stable", bus.INST_PC, prev_pc);
        chk1("hold_fault_stable", bus.INST_FAULT, prev_fault);
      end
      if (prev_req) begin
        chk1("req_held_until_gnt", bus.MEM_REQ, 1'b1);
        chk("addr_held_until_gnt", bus.MEM_ADDR, prev_addr);
      end
      if (bus.INST_VALID && bus.INST_READY && !bus.FLUSH) begin
        if (exp_inst_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL consume_unexpected: actual inst=%h required no consume", bus.INST);
        end else begin
          chk("consume_inst", bus.INST, exp_inst_q.pop_front());
          chk("consume_inst_pc", bus.INST_PC, exp_pc_q.pop_front());
          chk1("consume_fault", bus.INST_FAULT, exp_fault_q.pop_front());
        end
        model_count++;
      end
      prev_hold  = bus.INST_VALID && !bus.INST_READY && !bus.FLUSH;
      prev_req   = bus.MEM_REQ && !bus.MEM_GNT && !bus.FLUSH;
      prev_inst  = bus.INST;
      prev_pc    = bus.INST_PC;
      prev_fault = bus.INST_FAULT;
      prev_addr  = bus.MEM_ADDR;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic accept(input logic [31:0] pc);
    bus.PC       = pc;
    bus.PC_VALID = 1'b1;
    step();
    bus.PC_VALID = 1'b0;
  endtask

  task automatic grant();
    bus.MEM_GNT = 1'b1;
    step();
    bus.MEM_GNT = 1'b0;
  endtask

  task automatic respond(input logic [31:0] d);
    bus.MEM_RVALID = 1'b1;
    bus.MEM_RDATA  = d;
    step();
    bus.MEM_RVALID = 1'b0;
  endtask

  task automatic consume();
    bus.INST_READY = 1'b1;
    step();
    bus.INST_READY = 1'b0;
  endtask

  task automatic chk_idle(input string name);
    chk1({name, "_pc_ready"}, bus.PC_READY, 1'b1);
    chk1({name, "_inst_valid"}, bus.INST_VALID, 1'b0);
    chk1({name, "_mem_req"}, bus.MEM_REQ, 1'b0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    RESET_N        = 1'b0;
    bus.PC         = 32'd0;
    bus.PC_VALID   = 1'b0;
    bus.INST_READY = 1'b0;
    bus.FLUSH      = 1'b0;
    bus.MEM_GNT    = 1'b0;
    bus.MEM_RVALID = 1'b0;
    bus.MEM_RDATA  = 32'd0;
    repeat (2) step();

    // Reset values
    chk1("rst_mem_req", bus.MEM_REQ, 1'b0);
    chk1("rst_inst_valid", bus.INST_VALID, 1'b0);
    chk1("rst_inst_fault", bus.INST_FAULT, 1'b0);
    chk("rst_inst", bus.INST, NOP);
    chk("rst_inst_pc", bus.INST_PC, 32'h0000_0000);
    chk("rst_fetch_count", bus.FETCH_COUNT, 32'd0);
    RESET_N = 1'b1;
    step();
    chk1("rst_pc_ready", bus.PC_READY, 1'b1);

    // Zero-wait fetch: INST_VALID three cycles after acceptance
    expect_inst(32'h0050_0093, 32'h0000_0100, 1'b0);
    accept(32'h0000_0100);
    chk1("zw_mem_req", bus.MEM_REQ, 1'b1);
    chk("zw_mem_addr", bus.MEM_ADDR, 32'h0000_0100);
    chk1("zw_pc_ready", bus.PC_READY, 1'b0);
    chk1("zw_c1_valid", bus.INST_VALID, 1'b0);
    grant();
    chk1("zw_c2_valid", bus.INST_VALID, 1'b0);
    chk1("zw_c2_req", bus.MEM_REQ, 1'b0);
    respond(32'h0050_0093);
    chk1("zw_c3_valid", bus.INST_VALID, 1'b1);
    chk("zw_inst", bus.INST, 32'h0050_0093);
    chk("zw_inst_pc", bus.INST_PC, 32'h0000_0100);
    chk1("zw_fault", bus.INST_FAULT, 1'b0);
    consume();
    chk("zw_fetch_count", bus.FETCH_COUNT, 32'd1);
    chk_idle("zw_after");
    chk("zw_idle_inst_nop", bus.INST, NOP);

    // Backpressure: 5 cycles held, a pending PC_VALID must not be accepted
    expect_inst(32'h1234_5678, 32'h0000_0200, 1'b0);
    accept(32'h0000_0200);
    grant();
    respond(32'h1234_5678);
    bus.PC       = 32'h0000_0BAD;
    bus.PC_VALID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk1("bp_valid", bus.INST_VALID, 1'b1);
      chk("bp_inst", bus.INST, 32'h1234_5678);
      chk("bp_inst_pc", bus.INST_PC, 32'h0000_0200);
      chk1("bp_mem_req", bus.MEM_REQ, 1'b0);
      chk1("bp_pc_ready", bus.PC_READY, 1'b0);
      step();
    end
    bus.PC_VALID = 1'b0;
    consume();
    chk("bp_fetch_count", bus.FETCH_COUNT, 32'd2);
    chk_idle("bp_after");

    // Misaligned fetch
    expect_inst(NOP, 32'h0000_0102, 1'b1);
    accept(32'h0000_0102);
    chk1("mis_mem_req", bus.MEM_REQ, 1'b0);
    chk1("mis_valid", bus.INST_VALID, 1'b1);
    chk1("mis_fault", bus.INST_FAULT, 1'b1);
    chk("mis_inst", bus.INST, 32'h0000_0013);
    chk("mis_inst_pc", bus.INST_PC, 32'h0000_0102);
    consume();
    chk("mis_fetch_count", bus.FETCH_COUNT, 32'd3);
    chk1("mis_fault_clear", bus.INST_FAULT, 1'b0);

    // Flush in DATA, response two cycles later is drained
    accept(32'h0000_0300);
    grant();
    bus.FLUSH = 1'b1;
    step();
    bus.FLUSH = 1'b0;
    chk1("fd_drain_pc_ready", bus.PC_READY, 1'b0);
    chk1("fd_drain_valid", bus.INST_VALID, 1'b0);
    step();
    chk1("fd_drain2_valid", bus.INST_VALID, 1'b0);
    respond(32'hDEAD_BEEF);
    chk_idle("fd_after");
    step();
    chk1("fd_after2_valid", bus.INST_VALID, 1'b0);

    // Grant stall of 4 cycles, then complete
    expect_inst(32'hCAFE_0001, 32'h0000_0400, 1'b0);
    accept(32'h0000_0400);
    for (int i = 0; i < 4; i++) begin
      chk1("st_mem_req", bus.MEM_REQ, 1'b1);
      chk("st_mem_addr", bus.MEM_ADDR, 32'h0000_0400);
      step();
    end
    grant();
    respond(32'hCAFE_0001);
    consume();
    chk("st_fetch_count", bus.FETCH_COUNT, 32'd4);

    // Grant stall with FLUSH in the second ADDR cycle
    accept(32'h0000_0500);
    chk1("sf_c1_req", bus.MEM_REQ, 1'b1);
    step();
    chk("sf_c2_addr", bus.MEM_ADDR, 32'h0000_0500);
    bus.FLUSH = 1'b1;
    step();
    bus.FLUSH = 1'b0;
    chk_idle("sf_after");

    // FLUSH in IDLE does not block acceptance; FLUSH with GNT drains
    bus.FLUSH = 1'b1;
    accept(32'h0000_0700);
    bus.FLUSH = 1'b0;
    chk1("fi_mem_req", bus.MEM_REQ, 1'b1);
    chk("fi_mem_addr", bus.MEM_ADDR, 32'h0000_0700);
    bus.FLUSH = 1'b1;
    grant();
    bus.FLUSH = 1'b0;
    chk1("fg_drain_req", bus.MEM_REQ, 1'b0);
    chk1("fg_drain_pc_ready", bus.PC_READY, 1'b0);
    respond(32'h1111_1111);
    chk_idle("fg_after");

    // FLUSH in DATA together with RVALID discards the data
    accept(32'h0000_0800);
    grant();
    bus.FLUSH = 1'b1;
    respond(32'h2222_2222);
    bus.FLUSH = 1'b0;
    chk_idle("fr_after");

    // Stray response while idle is ignored
    respond(32'h4444_4444);
    chk_idle("stray");

    // FLUSH in HOLD with INST_READY: not counted
    accept(32'h0000_0900);
    grant();
    respond(32'h3333_3333);
    chk1("fh_valid", bus.INST_VALID, 1'b1);
    bus.FLUSH = 1'b1;
    consume();
    bus.FLUSH = 1'b0;
    chk("fh_fetch_count", bus.FETCH_COUNT, 32'd4);
    chk_idle("fh_after");
    chk("fh_inst_nop", bus.INST, NOP);

    // Reset in DATA, stale response after release ignored
    accept(32'h0000_0A00);
    grant();
    RESET_N = 1'b0;
    #1;
    chk1("rd_mem_req", bus.MEM_REQ, 1'b0);
    chk1("rd_valid", bus.INST_VALID, 1'b0);
    chk1("rd_fault", bus.INST_FAULT, 1'b0);
    chk("rd_inst", bus.INST, NOP);
    chk("rd_inst_pc", bus.INST_PC, 32'h0000_0000);
    chk("rd_fetch_count", bus.FETCH_COUNT, 32'd0);
    step();
    RESET_N = 1'b1;
    respond(32'hBADB_AD00);
    chk_idle("rd_after");
    chk("rd_after_count", bus.FETCH_COUNT, 32'd0);
    step();
    chk1("rd_after2_valid", bus.INST_VALID, 1'b0);

    // Normal operation resumes
    expect_inst(32'h00A0_0513, 32'h0000_0A04, 1'b0);
    accept(32'h0000_0A04);
    grant();
    respond(32'h00A0_0513);
    chk("re_inst", bus.INST, 32'h00A0_0513);
    consume();
    chk("re_fetch_count", bus.FETCH_COUNT, 32'd1);
    repeat (2) step();

    chk("model_queue_empty", exp_inst_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_fetch_responder.md
INST_FETCH_RESPONDER -- requirements
Module: inst_fetch_responder

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000, is the value of INST_PC after reset.
REQ-002 Parameter NOP_INST, default 32'h0000_0013 (ADDI x0,x0,0), is the INST value driven on fault or when idle.
REQ-003 CLOCK  input  1  single clock; all state updates on posedge CLOCK.
REQ-004 RESET_N  input  1  reset, asynchronous assert, active-low.
REQ-005 PC  input  32  fetch address from the core.
REQ-006 PC_VALID  input  1  core requests a fetch of PC.
REQ-007 PC_READY  output  1  unit accepts a request this cycle; high only in IDLE.
REQ-008 INST  output  32  instruction word delivered to the core.
REQ-009 INST_PC  output  32  address INST was fetched from.
REQ-010 INST_VALID  output  1  INST/INST_PC/INST_FAULT valid.
REQ-011 INST_READY  input  1  core consumes INST this cycle.
REQ-012 INST_FAULT  output  1  misaligned fetch; INST = NOP_INST.
REQ-013 FLUSH  input  1  core redirect; abandon current fetch.
REQ-014 MEM_REQ / MEM_ADDR  output  1 / 32  memory read request and word address.
REQ-015 MEM_GNT  input  1  memory accepts request this cycle.
REQ-016 MEM_RVALID / MEM_RDATA  input  1 / 32  read response, earliest the cycle after GNT.
REQ-017 FETCH_COUNT  output  32  count of instructions consumed (INST_VALID & INST_READY).

Function
REQ-018 FSM states: IDLE, ADDR, DATA, HOLD, DRAIN; one outstanding memory transaction maximum.
REQ-019 IDLE: PC_READY=1; on PC_VALID, latch PC; PC[1:0]!=0 -> HOLD with INST_FAULT=1, INST=NOP_INST, no MEM_REQ; else -> ADDR.
REQ-020 ADDR: MEM_REQ=1, MEM_ADDR=latched PC held stable until MEM_GNT; GNT -> DATA.
REQ-021 DATA: on MEM_RVALID capture MEM_RDATA into INST, INST_FAULT=0, -> HOLD; MEM_RVALID outside DATA/DRAIN ignored.
REQ-022 HOLD: INST_VALID=1, outputs stable; INST_READY -> IDLE, FETCH_COUNT +1 (wraps 32'hFFFF_FFFF -> 0).
REQ-023 Latency: zero-wait memory (GNT same cycle as REQ, RVALID next cycle) gives INST_VALID 3 cycles after PC accepted.
REQ-024 No back-to-back overlap: a new request is accepted no earlier than the cycle after INST consumed.
REQ-025 FLUSH in IDLE: no effect; PC_VALID same cycle still accepted.
REQ-026 FLUSH in ADDR without GNT: drop MEM_REQ next cycle, -> IDLE.
REQ-027 FLUSH in ADDR with GNT same cycle, or in DATA without RVALID: -> DRAIN.
REQ-028 FLUSH in DATA with RVALID same cycle: data discarded, -> IDLE.
REQ-029 DRAIN: PC_READY=0, INST_VALID=0; on MEM_RVALID discard data, -> IDLE.
REQ-030 FLUSH in HOLD: INST discarded, FETCH_COUNT unchanged even if INST_READY high, -> IDLE.
REQ-031 INST_VALID and MEM_REQ never both high; INST_VALID low in all states except HOLD.
REQ-032 Word address only: MEM_ADDR[1:0] always 2'b00.

Reset
REQ-033 RESET_N low asynchronously forces IDLE, MEM_REQ=0, INST_VALID=0, INST_FAULT=0, INST=NOP_INST, INST_PC=RESET_VECTOR, FETCH_COUNT=0, PC_READY=1 once released.
REQ-034 Reset mid-transaction abandons it; a memory response arriving after release while in IDLE is ignored.

Verification
REQ-035 Zero-wait fetch: PC=0x100, memory returns 0x00500093 -> INST_VALID cycle 3, INST=0x00500093, INST_PC=0x100, FETCH_COUNT=1 after INST_READY.
REQ-036 Backpressure: INST_READY low 5 cycles -> INST/INST_PC stable, no MEM_REQ, PC_READY=0 throughout.
REQ-037 Misaligned: PC=0x102 -> no MEM_REQ, INST_VALID next cycle, INST_FAULT=1, INST=0x00000013.
REQ-038 Flush in DATA: GNT then FLUSH, RVALID 2 cycles later with 0xDEADBEEF -> INST_VALID never asserts, unit in IDLE after response.
REQ-039 GNT stall: MEM_GNT low 4 cycles -> MEM_REQ and MEM_ADDR held constant; FLUSH in cycle 2 -> MEM_REQ low next cycle.
REQ-040 Reset mid-DATA: RESET_N low -> all outputs at reset values immediately; stale RVALID after release ignored, FETCH_COUNT=0.
